// File: rtl/irq_ctrl.sv
// irq_ctrl: vectored, maskable, fixed-priority interrupt controller for the single-cycle MIPS core.
// Edge-detects N_SRC request lines into PENDING, redirects the core to a per-source vector and
// blocks nesting until the ISR returns with eret.
module irq_ctrl #(
    parameter int unsigned N_SRC      = 4,
    parameter logic [31:0] ISR_BASE   = 32'h0000_0100,
    parameter int unsigned ISR_STRIDE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [31:0]      pc_current,
    input  logic             eret,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             take_irq,
    output logic [31:0]      vec_addr,
    output logic             ret_valid,
    output logic [31:0]      epc,
    output logic             in_service
);

    localparam logic [1:0] AddrMask    = 2'd0;
    localparam logic [1:0] AddrPending = 2'd1;
    localparam logic [1:0] AddrCause   = 2'd2;
    localparam logic [1:0] AddrEpc     = 2'd3;

    typedef enum logic [1:0] {StIdle, StTake, StService, StRet} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             gie_q, gie_d;
    logic [3:0]       cause_q, cause_d;
    logic [31:0]      epc_q, epc_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] winner_oh;
    logic [N_SRC-1:0] clr_sw;
    logic [N_SRC-1:0] clr_take;
    logic [3:0]       winner;
    logic             unused_wdata;

    assign rise         = irq_in & ~irq_q;
    assign eligible     = pending_q & mask_q & {N_SRC{gie_q}};
    // Bits between the source enables and GIE have no storage behind them.
    assign unused_wdata = ^reg_wdata[30:N_SRC];

    // Priority pick: scanning downward leaves the lowest-index eligible source as winner.
    always_comb begin
        winner    = 4'd0;
        winner_oh = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = 4'(i);
                winner_oh    = '0;
                winner_oh[i] = 1'b1;
            end
        end
    end

    // FSM next state, capture of cause/epc on entry, and the one-cycle redirect pulses.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        clr_take  = '0;
        take_irq  = 1'b0;
        ret_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d  = StTake;
                    cause_d  = winner;
                    epc_d    = pc_current;
                    clr_take = winner_oh;
                end
            end
            StTake: begin
                take_irq = 1'b1;
                state_d  = StService;
            end
            StService: begin
                if (eret) begin
                    state_d = StRet;
                end
            end
            StRet: begin
                ret_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Register-file writes; a new edge beats any clear of the same bit in the same cycle.
    always_comb begin
        clr_sw = '0;
        mask_d = mask_q;
        gie_d  = gie_q;
        if (reg_we && reg_addr == AddrPending) begin
            clr_sw = reg_wdata[N_SRC-1:0];
        end
        if (reg_we && reg_addr == AddrMask) begin
            mask_d = reg_wdata[N_SRC-1:0];
            gie_d  = reg_wdata[31];
        end
        pending_d = (pending_q & ~(clr_sw | clr_take)) | rise;
    end

    // Combinational register read mux; unused bits read zero.
    always_comb begin
        reg_rdata = '0;
        unique case (reg_addr)
            AddrMask: begin
                reg_rdata[N_SRC-1:0] = mask_q;
                reg_rdata[31]        = gie_q;
            end
            AddrPending: reg_rdata[N_SRC-1:0] = pending_q;
            AddrCause: begin
                reg_rdata[31]  = in_service;
                reg_rdata[3:0] = cause_q;
            end
            AddrEpc: reg_rdata = epc_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            cause_q   <= 4'd0;
            epc_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_in;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
        end
    end

    assign epc        = epc_q;
    assign in_service = (state_q != StIdle);
    assign vec_addr   = ISR_BASE + 32'(cause_q) * ISR_STRIDE;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the controller.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq = '0;
    logic [31:0] pc = '0;
    logic        eret = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        take_irq;
    logic [31:0] vec_addr;
    logic        ret_valid;
    logic [31:0] epc;
    logic        in_service;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl #(
        .N_SRC     (4),
        .ISR_BASE  (32'h0000_0100),
        .ISR_STRIDE(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq),
        .pc_current(pc),
        .eret      (eret),
        .reg_we    (we),
        .reg_addr  (addr),
        .reg_wdata (wdata),
        .reg_rdata (rdata),
        .take_irq  (take_irq),
        .vec_addr  (vec_addr),
        .ret_valid (ret_valid),
        .epc       (epc),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        irq = '0; eret = 1'b0; we = 1'b0; pc = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        n_checks++; if (take_irq !== 1'b0) begin n_fail++; $display("FAIL reset_take: got %b want 0", take_irq); end
        n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ret: got %b want 0", ret_valid); end
        n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_insvc: got %b want 0", in_service); end
        n_checks++; if (vec_addr !== 32'h100) begin n_fail++; $display("FAIL reset_vec: got %h want 00000100", vec_addr); end
        n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
        rd(2'd0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", r); end
        rd(2'd1, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", r); end
        rd(2'd2, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_cause: got %h want 0", r); end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        do_reset();
        wr(2'd0, 32'h8000_0004);
        irq = 4'b0100; pc = 32'h40;
        tick();
        n_checks++; if (take_irq !== 1'b0) begin n_fail++; $display("FAIL basic_early_take: got %b want 0", take_irq); end
        rd(2'd1, r);
        n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL basic_pend_set: got %h want 4", r); end
        tick();
        pc = 32'h44;
        n_checks++; if (take_irq !== 1'b1) begin n_fail++; $display("FAIL basic_take: got %b want 1", take_irq); end
        n_checks++; if (vec_addr !== 32'h120) begin n_fail++; $display("FAIL basic_vec: got %h want 00000120", vec_addr); end
        n_checks++; if (epc !== 32'h40) begin n_fail++; $display("FAIL basic_epc: got %h want 00000040", epc); end
        rd(2'd2, r);
        n_checks++; if (r !== 32'h8000_0002) begin n_fail++; $display("FAIL basic_cause: got %h want 80000002", r); end
        rd(2'd1, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL basic_pend_clr: got %h want 0", r); end
        tick();
        n_checks++; if (take_irq !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL basic_service: got take=%b insvc=%b want 0/1", take_irq, in_service); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (ret_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ret: got %b want 1", ret_valid); end
        n_checks++; if (epc !== 32'h40) begin n_fail++; $display("FAIL basic_ret_epc: got %h want 00000040", epc); end
        n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL basic_ret_insvc: got %b want 1", in_service); end
        tick();
        n_checks++; if (ret_valid !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL basic_done: got ret=%b insvc=%b want 0/0", ret_valid, in_service); end
        irq = '0;
    endtask

    task automatic test_priority();
        do_reset();
        wr(2'd0, 32'h8000_000F);
        irq = 4'b1010;
        tick();
        tick();
        irq = '0;
        n_checks++; if (take_irq !== 1'b1 || vec_addr !== 32'h110) begin n_fail++; $display("FAIL prio_first: got take=%b vec=%h want 1/00000110", take_irq, vec_addr); end
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (ret_valid !== 1'b1) begin n_fail++; $display("FAIL prio_ret: got %b want 1", ret_valid); end
        tick();
        n_checks++; if (take_irq !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %b want 0", take_irq); end
        tick();
        n_checks++; if (take_irq !== 1'b1 || vec_addr !== 32'h130) begin n_fail++; $display("FAIL prio_second: got take=%b vec=%h want 1/00000130", take_irq, vec_addr); end
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_mask_gie();
        logic [31:0] r;
        do_reset();
        wr(2'd0, 32'h0000_0001);
        irq = 4'b0001;
        tick();
        irq = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (take_irq !== 1'b0) begin n_fail++; $display("FAIL gie_off_take: got %b want 0", take_irq); end
        end
        rd(2'd1, r);
        n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL gie_off_pend: got %h want 1", r); end
        wr(2'd0, 32'h8000_0001);
        n_checks++; if (take_irq !== 1'b0) begin n_fail++; $display("FAIL gie_on_early: got %b want 0", take_irq); end
        tick();
        n_checks++; if (take_irq !== 1'b1 || vec_addr !== 32'h100) begin n_fail++; $display("FAIL gie_on_take: got take=%b vec=%h want 1/00000100", take_irq, vec_addr); end
        rd(2'd1, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL gie_on_pend: got %h want 0", r); end
    endtask

    task automatic test_no_nesting();
        logic [31:0] r;
        do_reset();
        wr(2'd0, 32'h8000_0005);
        irq = 4'b0100;
        tick();
        tick();
        n_checks++; if (take_irq !== 1'b1 || vec_addr !== 32'h120) begin n_fail++; $display("FAIL nest_first: got take=%b vec=%h want 1/00000120", take_irq, vec_addr); end
        irq = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (take_irq !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL nest_blocked: got take=%b insvc=%b want 0/1", take_irq, in_service); end
        end
        rd(2'd1, r);
        n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL nest_pend: got %h want 1", r); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (ret_valid !== 1'b1) begin n_fail++; $display("FAIL nest_ret: got %b want 1", ret_valid); end
        tick();
        tick();
        n_checks++; if (take_irq !== 1'b1 || vec_addr !== 32'h100) begin n_fail++; $display("FAIL nest_second: got take=%b vec=%h want 1/00000100", take_irq, vec_addr); end
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (take_irq !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL nest_level_hold: got take=%b insvc=%b want 0/0", take_irq, in_service); end
        end
        rd(2'd1, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL nest_level_pend: got %h want 0", r); end
        irq = '0;
    endtask

    task automatic test_w1c_race();
        logic [31:0] r;
        do_reset();
        tick();
        irq = 4'b0001; we = 1'b1; addr = 2'd1; wdata = 32'h1;
        tick();
        we = 1'b0;
        rd(2'd1, r);
        n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL w1c_race: got %h want 1", r); end
        irq = '0;
        tick();
        wr(2'd1, 32'h1);
        rd(2'd1, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        do_reset();
        wr(2'd0, 32'h8000_0002);
        irq = 4'b0010; pc = 32'h88;
        tick();
        tick();
        irq = '0;
        tick();
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd2, r);
        n_checks++; if (r !== 32'h8000_0001) begin n_fail++; $display("FAIL ro_cause: got %h want 80000001", r); end
        rd(2'd3, r);
        n_checks++; if (r !== 32'h88) begin n_fail++; $display("FAIL ro_epc: got %h want 00000088", r); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (in_service !== 1'b0 || ret_valid !== 1'b0 || epc !== 32'h0) begin n_fail++; $display("FAIL rstmid_state: got insvc=%b ret=%b epc=%h want 0/0/0", in_service, ret_valid, epc); end
        rd(2'd0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rstmid_mask: got %h want 0", r); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_eret: got %b want 0", ret_valid); end
        tick();
        n_checks++; if (ret_valid !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got ret=%b insvc=%b want 0/0", ret_valid, in_service); end
    endtask

    // Randomized run: the model tracks the controller as "servicing / redirect due / return due"
    // flags and recomputes the winner as the lowest set bit of the eligible vector.
    task automatic test_random();
        bit [3:0]    m_pend, m_mask, m_prev, elig, rise, clr, lowbit;
        bit          m_gie, m_svc, m_take, m_ret;
        int          m_cause;
        bit [31:0]   m_epc, exp_r;
        logic [31:0] r;
        logic [1:0]  ra;
        do_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_gie = 0;
        m_svc = 0; m_take = 0; m_ret = 0; m_cause = 0; m_epc = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) irq[b] = ~irq[b];
            end
            pc    = $urandom & 32'hFFFF_FFFC;
            eret  = ($urandom_range(0, 5) == 0);
            we    = ($urandom_range(0, 5) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if (addr == 2'd0) wdata[31] = ($urandom_range(0, 3) != 0);

            elig = m_pend & m_mask & {4{m_gie}};
            rise = irq & ~m_prev;
            clr  = (we && addr == 2'd1) ? wdata[3:0] : 4'b0;
            if (m_take) begin
                m_take = 0;
            end else if (m_ret) begin
                m_ret = 0;
                m_svc = 0;
            end else if (m_svc) begin
                if (eret) m_ret = 1;
            end else if (elig != 0) begin
                lowbit = elig & (~elig + 4'd1);
                for (int b = 0; b < 4; b++) if (lowbit == (4'd1 << b)) m_cause = b;
                m_epc  = pc;
                clr    = clr | lowbit;
                m_take = 1;
                m_svc  = 1;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (we && addr == 2'd0) begin
                m_mask = wdata[3:0];
                m_gie  = wdata[31];
            end
            m_prev = irq;

            tick();
            we = 1'b0;
            n_checks++; if (take_irq !== m_take) begin n_fail++; $display("FAIL rnd_take cyc %0d: got %b want %b", cyc, take_irq, m_take); end
            n_checks++; if (ret_valid !== m_ret) begin n_fail++; $display("FAIL rnd_ret cyc %0d: got %b want %b", cyc, ret_valid, m_ret); end
            n_checks++; if (in_service !== m_svc) begin n_fail++; $display("FAIL rnd_insvc cyc %0d: got %b want %b", cyc, in_service, m_svc); end
            n_checks++; if (epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc cyc %0d: got %h want %h", cyc, epc, m_epc); end
            n_checks++; if (vec_addr !== 32'h100 + 32'(m_cause) * 32'd16) begin n_fail++; $display("FAIL rnd_vec cyc %0d: got %h want %h", cyc, vec_addr, 32'h100 + 32'(m_cause) * 32'd16); end
            ra = 2'($urandom_range(0, 3));
            case (ra)
                2'd0:    exp_r = {m_gie, 27'b0, m_mask};
                2'd1:    exp_r = {28'b0, m_pend};
                2'd2:    exp_r = {m_svc, 27'b0, 4'(m_cause)};
                default: exp_r = m_epc;
            endcase
            rd(ra, r);
            n_checks++; if (r !== exp_r) begin n_fail++; $display("FAIL rnd_reg%0d cyc %0d: got %h want %h", ra, cyc, r, exp_r); end
        end
        irq = '0; eret = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask_gie();
        test_no_nesting();
        test_w1c_race();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
